// File: rtl/rs_fpga_param_pkg.sv
// ---------------------------------------------------------------------------
// rs_fpga_param_pkg
// Shared definitions for the parametrised FPGA-unit reservation station.
//   - default sizes for entries, snoop ports, operand/tag widths
//   - payload_t: field layout of the opaque packed payload (PAY_W bits)
//   - spec_kill(): true when an entry's branch tag hits a mispredict kill mask
// ---------------------------------------------------------------------------
package rs_fpga_param_pkg;

    localparam int ENT_NUM_DEF     = 4;
    localparam int ENT_SEL_DEF     = 2;
    localparam int NUM_WB_DEF      = 7;
    localparam int DATA_LEN_DEF    = 32;
    localparam int RRF_SEL_DEF     = 6;
    localparam int SPECTAG_LEN_DEF = 5;
    localparam int PAY_W_DEF       = 108;

    // Everything that is not a named decode field is carried as passbits.
    localparam int PASSBITS_W = PAY_W_DEF - 53;

    typedef struct packed {
        logic [31:0]             imm;
        logic [5:0]              rrftag;
        logic                    dstval;
        logic [1:0]              src_a;
        logic [1:0]              src_b;
        logic [6:0]              funct7;
        logic [2:0]              funct3;
        logic [PASSBITS_W-1:0]   passbits;
    } payload_t;

    function automatic logic spec_kill(input logic [SPECTAG_LEN_DEF-1:0] spectag,
                                       input logic [SPECTAG_LEN_DEF-1:0] mask);
        return |(spectag & mask);
    endfunction

endpackage

// File: rtl/rs_fpga_param_ent.sv
// ---------------------------------------------------------------------------
// rs_fpga_param_ent
// One reservation-station entry: two source operands with result-bus wakeup,
// opaque payload and branch tag. Occupancy is owned by the top level and fed
// in on busy_i.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   busy_i                entry is occupied (enables wakeup of stored operands)
//   we_i                  accepted allocation into this entry
//   wsrc*_i / wvalid*_i   incoming operand value or pending RRF tag
//   wpayload_i/wspectag_i incoming payload and branch tag
//   exrslt_i/exdst_i      snooped result buses and destination tags
//   kill_spec_i           per-port squash of the bus result
//   ready_o               busy with both operands valid (registered view)
//   ex_src*_o             operands with same-cycle wakeup data forwarded
//   payload_o/spectag_o   stored payload and branch tag
// ---------------------------------------------------------------------------
module rs_fpga_param_ent
    import rs_fpga_param_pkg::*;
#(
    parameter int NUM_WB      = NUM_WB_DEF,
    parameter int DATA_LEN    = DATA_LEN_DEF,
    parameter int RRF_SEL     = RRF_SEL_DEF,
    parameter int SPECTAG_LEN = SPECTAG_LEN_DEF,
    parameter int PAY_W       = PAY_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         busy_i,
    input  logic                         we_i,
    input  logic [DATA_LEN-1:0]          wsrc1_i,
    input  logic [DATA_LEN-1:0]          wsrc2_i,
    input  logic                         wvalid1_i,
    input  logic                         wvalid2_i,
    input  logic [PAY_W-1:0]             wpayload_i,
    input  logic [SPECTAG_LEN-1:0]       wspectag_i,
    input  logic [NUM_WB*DATA_LEN-1:0]   exrslt_i,
    input  logic [NUM_WB*RRF_SEL-1:0]    exdst_i,
    input  logic [NUM_WB-1:0]            kill_spec_i,
    output logic                         ready_o,
    output logic [DATA_LEN-1:0]          ex_src1_o,
    output logic [DATA_LEN-1:0]          ex_src2_o,
    output logic [PAY_W-1:0]             payload_o,
    output logic [SPECTAG_LEN-1:0]       spectag_o
);

    logic [DATA_LEN-1:0]    src1_q, src1_d, src2_q, src2_d;
    logic                   valid1_q, valid1_d, valid2_q, valid2_d;
    logic [PAY_W-1:0]       payload_q, payload_d;
    logic [SPECTAG_LEN-1:0] spectag_q, spectag_d;

    logic [RRF_SEL-1:0]     tag1, tag2;
    logic                   pend1, pend2;
    logic                   hit1, hit2;
    logic [DATA_LEN-1:0]    data1, data2;
    logic                   wake1, wake2;

    // In the alloc cycle the incoming tags are snooped so a result that is on
    // the bus right now is not missed.
    assign tag1  = we_i ? wsrc1_i[RRF_SEL-1:0] : src1_q[RRF_SEL-1:0];
    assign tag2  = we_i ? wsrc2_i[RRF_SEL-1:0] : src2_q[RRF_SEL-1:0];
    assign pend1 = we_i ? !wvalid1_i : (busy_i && !valid1_q);
    assign pend2 = we_i ? !wvalid2_i : (busy_i && !valid2_q);

    // Scan from the top port down so the lowest matching port wins.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (!kill_spec_i[p] && (exdst_i[p*RRF_SEL +: RRF_SEL] == tag1)) begin
                hit1  = 1'b1;
                data1 = exrslt_i[p*DATA_LEN +: DATA_LEN];
            end
            if (!kill_spec_i[p] && (exdst_i[p*RRF_SEL +: RRF_SEL] == tag2)) begin
                hit2  = 1'b1;
                data2 = exrslt_i[p*DATA_LEN +: DATA_LEN];
            end
        end
    end

    assign wake1 = pend1 && hit1;
    assign wake2 = pend2 && hit2;

    always_comb begin
        src1_d    = src1_q;
        src2_d    = src2_q;
        valid1_d  = valid1_q;
        valid2_d  = valid2_q;
        payload_d = payload_q;
        spectag_d = spectag_q;
        if (we_i) begin
            src1_d    = wake1 ? data1 : wsrc1_i;
            src2_d    = wake2 ? data2 : wsrc2_i;
            valid1_d  = wvalid1_i || wake1;
            valid2_d  = wvalid2_i || wake2;
            payload_d = wpayload_i;
            spectag_d = wspectag_i;
        end else begin
            if (wake1) begin
                src1_d   = data1;
                valid1_d = 1'b1;
            end
            if (wake2) begin
                src2_d   = data2;
                valid2_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src1_q    <= '0;
            src2_q    <= '0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            payload_q <= '0;
            spectag_q <= '0;
        end else begin
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            valid1_q  <= valid1_d;
            valid2_q  <= valid2_d;
            payload_q <= payload_d;
            spectag_q <= spectag_d;
        end
    end

    // Ready uses registered valids only; forwarded data shows up on ex_src
    // but the entry becomes issuable one cycle later.
    assign ready_o   = busy_i && valid1_q && valid2_q;
    assign ex_src1_o = (wake1 && !we_i) ? data1 : src1_q;
    assign ex_src2_o = (wake2 && !we_i) ? data2 : src2_q;
    assign payload_o = payload_q;
    assign spectag_o = spectag_q;

endmodule

// File: rtl/rs_fpga_param.sv
// ---------------------------------------------------------------------------
// rs_fpga_param
// FPGA-unit reservation station with ENT_NUM entries. Owns occupancy, the
// speculation bits and an age matrix; selects the oldest ready entry and
// offers it on a valid/ack issue handshake.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   we1/we2, waddr1/waddr2         two alloc slots per cycle, slot 1 older
//   wsrc*_k, wvalid*_k, wpayload_k, wspectag_k, wspecbit_k  alloc data (k=1,2)
//   busyvec, free_cnt              occupancy and free-entry count (registered)
//   prmiss, prsuccess, prtag, specfixtag  branch resolution
//   exrslt, exdst, kill_spec       result-bus snoop
//   issue_valid/issue_ack/issue_addr      issue handshake
//   ex_src1, ex_src2, payload, spectag, specbit  selected entry contents
// ---------------------------------------------------------------------------
module rs_fpga_param
    import rs_fpga_param_pkg::*;
#(
    parameter int ENT_NUM     = ENT_NUM_DEF,
    parameter int ENT_SEL     = ENT_SEL_DEF,
    parameter int NUM_WB      = NUM_WB_DEF,
    parameter int DATA_LEN    = DATA_LEN_DEF,
    parameter int RRF_SEL     = RRF_SEL_DEF,
    parameter int SPECTAG_LEN = SPECTAG_LEN_DEF,
    parameter int PAY_W       = PAY_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we1,
    input  logic                         we2,
    input  logic [ENT_SEL-1:0]           waddr1,
    input  logic [ENT_SEL-1:0]           waddr2,
    input  logic [DATA_LEN-1:0]          wsrc1_1,
    input  logic [DATA_LEN-1:0]          wsrc2_1,
    input  logic [DATA_LEN-1:0]          wsrc1_2,
    input  logic [DATA_LEN-1:0]          wsrc2_2,
    input  logic                         wvalid1_1,
    input  logic                         wvalid2_1,
    input  logic                         wvalid1_2,
    input  logic                         wvalid2_2,
    input  logic [PAY_W-1:0]             wpayload_1,
    input  logic [PAY_W-1:0]             wpayload_2,
    input  logic [SPECTAG_LEN-1:0]       wspectag_1,
    input  logic [SPECTAG_LEN-1:0]       wspectag_2,
    input  logic                         wspecbit_1,
    input  logic                         wspecbit_2,
    output logic [ENT_NUM-1:0]           busyvec,
    output logic [ENT_SEL:0]             free_cnt,
    input  logic                         prmiss,
    input  logic                         prsuccess,
    input  logic [SPECTAG_LEN-1:0]       prtag,
    input  logic [SPECTAG_LEN-1:0]       specfixtag,
    input  logic [NUM_WB*DATA_LEN-1:0]   exrslt,
    input  logic [NUM_WB*RRF_SEL-1:0]    exdst,
    input  logic [NUM_WB-1:0]            kill_spec,
    output logic                         issue_valid,
    input  logic                         issue_ack,
    output logic [ENT_SEL-1:0]           issue_addr,
    output logic [DATA_LEN-1:0]          ex_src1,
    output logic [DATA_LEN-1:0]          ex_src2,
    output logic [PAY_W-1:0]             payload,
    output logic [SPECTAG_LEN-1:0]       spectag,
    output logic                         specbit
);

    logic [ENT_NUM-1:0]                busy_q, busy_d;
    logic [ENT_NUM-1:0]                specbit_q, specbit_d;
    // older_q[i][j]: entry i was allocated before entry j
    logic [ENT_NUM-1:0][ENT_NUM-1:0]   older_q, older_d;

    logic                              same_addr;
    logic                              alloc1, alloc2;
    logic [ENT_NUM-1:0]                ent_we;
    logic [ENT_NUM-1:0]                ready;
    logic [ENT_NUM-1:0]                blocked;
    logic [ENT_NUM-1:0]                grant;
    logic [ENT_SEL-1:0]                sel_idx;
    logic                              issue_fire;
    logic                              succ_live;

    logic [DATA_LEN-1:0]               ent_src1    [ENT_NUM];
    logic [DATA_LEN-1:0]               ent_src2    [ENT_NUM];
    logic [PAY_W-1:0]                  ent_payload [ENT_NUM];
    logic [SPECTAG_LEN-1:0]            ent_spectag [ENT_NUM];

    // A colliding dual alloc or an alloc onto a busy entry is dropped whole;
    // a mispredict drops every alloc of the cycle.
    assign same_addr = we1 && we2 && (waddr1 == waddr2);
    assign alloc1    = we1 && !busy_q[waddr1] && !same_addr && !prmiss;
    assign alloc2    = we2 && !busy_q[waddr2] && !same_addr && !prmiss;
    assign succ_live = prsuccess && !prmiss;

    for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
        logic slot1;
        assign slot1     = alloc1 && (waddr1 == ENT_SEL'(g));
        assign ent_we[g] = slot1 || (alloc2 && (waddr2 == ENT_SEL'(g)));

        rs_fpga_param_ent #(
            .NUM_WB      (NUM_WB),
            .DATA_LEN    (DATA_LEN),
            .RRF_SEL     (RRF_SEL),
            .SPECTAG_LEN (SPECTAG_LEN),
            .PAY_W       (PAY_W)
        ) u_ent (
            .clk         (clk),
            .reset       (reset),
            .busy_i      (busy_q[g]),
            .we_i        (ent_we[g]),
            .wsrc1_i     (slot1 ? wsrc1_1    : wsrc1_2),
            .wsrc2_i     (slot1 ? wsrc2_1    : wsrc2_2),
            .wvalid1_i   (slot1 ? wvalid1_1  : wvalid1_2),
            .wvalid2_i   (slot1 ? wvalid2_1  : wvalid2_2),
            .wpayload_i  (slot1 ? wpayload_1 : wpayload_2),
            .wspectag_i  (slot1 ? wspectag_1 : wspectag_2),
            .exrslt_i    (exrslt),
            .exdst_i     (exdst),
            .kill_spec_i (kill_spec),
            .ready_o     (ready[g]),
            .ex_src1_o   (ent_src1[g]),
            .ex_src2_o   (ent_src2[g]),
            .payload_o   (ent_payload[g]),
            .spectag_o   (ent_spectag[g])
        );
    end

    // Oldest-ready select: an entry loses if any other ready entry is older.
    // The age matrix yields a single winner; the encoder still breaks ties
    // toward the lowest index so a corrupted matrix cannot yield two.
    always_comb begin
        blocked = '0;
        grant   = '0;
        sel_idx = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            for (int j = 0; j < ENT_NUM; j++) begin
                if (ready[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            grant[i] = ready[i] && !blocked[i];
        end
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            if (grant[i]) begin
                sel_idx = ENT_SEL'(i);
            end
        end
    end

    assign issue_valid = |ready;
    assign issue_fire  = issue_valid && issue_ack;
    assign issue_addr  = sel_idx;
    assign ex_src1     = ent_src1[sel_idx];
    assign ex_src2     = ent_src2[sel_idx];
    assign payload     = ent_payload[sel_idx];
    assign spectag     = ent_spectag[sel_idx];
    assign specbit     = specbit_q[sel_idx] && !(succ_live && (ent_spectag[sel_idx] == prtag));

    always_comb begin
        busy_d    = busy_q;
        specbit_d = specbit_q;
        older_d   = older_q;

        if (issue_fire) begin
            busy_d[sel_idx] = 1'b0;
        end

        if (prmiss) begin
            for (int i = 0; i < ENT_NUM; i++) begin
                if (spec_kill(ent_spectag[i], specfixtag)) begin
                    busy_d[i] = 1'b0;
                end
            end
            specbit_d = '0;
        end else begin
            if (prsuccess) begin
                for (int i = 0; i < ENT_NUM; i++) begin
                    if (ent_spectag[i] == prtag) begin
                        specbit_d[i] = 1'b0;
                    end
                end
            end
            // Allocated entries were free, so their stale tag compare above is
            // overwritten here with the incoming tag's result.
            if (alloc1) begin
                busy_d[waddr1]    = 1'b1;
                specbit_d[waddr1] = wspecbit_1 && !(prsuccess && (wspectag_1 == prtag));
                older_d[waddr1]   = '0;
                for (int i = 0; i < ENT_NUM; i++) begin
                    if (busy_q[i]) begin
                        older_d[i][waddr1] = 1'b1;
                    end
                end
            end
            if (alloc2) begin
                busy_d[waddr2]    = 1'b1;
                specbit_d[waddr2] = wspecbit_2 && !(prsuccess && (wspectag_2 == prtag));
                older_d[waddr2]   = '0;
                for (int i = 0; i < ENT_NUM; i++) begin
                    if (busy_q[i]) begin
                        older_d[i][waddr2] = 1'b1;
                    end
                end
                if (alloc1) begin
                    older_d[waddr1][waddr2] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= '0;
            specbit_q <= '0;
            older_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            specbit_q <= specbit_d;
            older_q   <= older_d;
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy_q[i]) begin
                free_cnt = free_cnt + (ENT_SEL+1)'(1);
            end
        end
    end

    assign busyvec = busy_q;

endmodule

// File: tb/tb_rs_fpga_param.sv
module tb_rs_fpga_param;
    import rs_fpga_param_pkg::*;

    localparam int EN  = 4;
    localparam int ES  = 2;
    localparam int NW  = 7;
    localparam int DL  = 32;
    localparam int RS  = 6;
    localparam int ST  = 5;
    localparam int PW  = 108;

    logic            clk = 1'b0;
    logic            reset;
    logic            we1, we2;
    logic [ES-1:0]   waddr1, waddr2;
    logic [DL-1:0]   wsrc1_1, wsrc2_1, wsrc1_2, wsrc2_2;
    logic            wvalid1_1, wvalid2_1, wvalid1_2, wvalid2_2;
    logic [PW-1:0]   wpayload_1, wpayload_2;
    logic [ST-1:0]   wspectag_1, wspectag_2;
    logic            wspecbit_1, wspecbit_2;
    logic [EN-1:0]   busyvec;
    logic [ES:0]     free_cnt;
    logic            prmiss, prsuccess;
    logic [ST-1:0]   prtag, specfixtag;
    logic [NW*DL-1:0] exrslt;
    logic [NW*RS-1:0] exdst;
    logic [NW-1:0]   kill_spec;
    logic            issue_valid, issue_ack;
    logic [ES-1:0]   issue_addr;
    logic [DL-1:0]   ex_src1, ex_src2;
    logic [PW-1:0]   payload;
    logic [ST-1:0]   spectag;
    logic            specbit;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [PW-1:0] P0 = 108'h0A0_0000_0000_0000_0000_0000_0001;
    localparam logic [PW-1:0] P1 = 108'h0B0_0000_0000_0000_0000_0000_0002;
    localparam logic [PW-1:0] P2 = 108'h0C0_0000_0000_0000_0000_0000_0003;
    localparam logic [PW-1:0] P3 = 108'h0D0_0000_0000_0000_0000_0000_0004;
    localparam logic [PW-1:0] P4 = 108'h0E0_0000_0000_0000_0000_0000_0005;
    localparam logic [PW-1:0] P5 = 108'h0F0_0000_0000_0000_0000_0000_0006;
    localparam logic [PW-1:0] P6 = 108'h123_0000_0000_0000_0000_0000_0007;
    localparam logic [PW-1:0] P7 = 108'h456_0000_0000_0000_0000_0000_0008;
    localparam logic [PW-1:0] P8 = 108'h789_0000_0000_0000_0000_0000_0009;

    always #5 clk = ~clk;

    rs_fpga_param dut (
        .clk(clk), .reset(reset),
        .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
        .wsrc1_1(wsrc1_1), .wsrc2_1(wsrc2_1), .wsrc1_2(wsrc1_2), .wsrc2_2(wsrc2_2),
        .wvalid1_1(wvalid1_1), .wvalid2_1(wvalid2_1), .wvalid1_2(wvalid1_2), .wvalid2_2(wvalid2_2),
        .wpayload_1(wpayload_1), .wpayload_2(wpayload_2),
        .wspectag_1(wspectag_1), .wspectag_2(wspectag_2),
        .wspecbit_1(wspecbit_1), .wspecbit_2(wspecbit_2),
        .busyvec(busyvec), .free_cnt(free_cnt),
        .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag), .specfixtag(specfixtag),
        .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec),
        .issue_valid(issue_valid), .issue_ack(issue_ack), .issue_addr(issue_addr),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .payload(payload),
        .spectag(spectag), .specbit(specbit)
    );

    task automatic expect_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; waddr1 = 0; waddr2 = 0;
        wsrc1_1 = 0; wsrc2_1 = 0; wsrc1_2 = 0; wsrc2_2 = 0;
        wvalid1_1 = 0; wvalid2_1 = 0; wvalid1_2 = 0; wvalid2_2 = 0;
        wpayload_1 = 0; wpayload_2 = 0; wspectag_1 = 0; wspectag_2 = 0;
        wspecbit_1 = 0; wspecbit_2 = 0;
        prmiss = 0; prsuccess = 0; prtag = 0; specfixtag = 0;
        exrslt = 0; exdst = 0; kill_spec = '1;
        issue_ack = 0;
    endtask

    task automatic alloc1(input logic [ES-1:0] a, input logic [DL-1:0] s1, input logic v1,
                          input logic [DL-1:0] s2, input logic v2, input logic [PW-1:0] p,
                          input logic [ST-1:0] t, input logic sb);
        we1 = 1; waddr1 = a; wsrc1_1 = s1; wvalid1_1 = v1; wsrc2_1 = s2; wvalid2_1 = v2;
        wpayload_1 = p; wspectag_1 = t; wspecbit_1 = sb;
    endtask

    task automatic alloc2(input logic [ES-1:0] a, input logic [DL-1:0] s1, input logic v1,
                          input logic [DL-1:0] s2, input logic v2, input logic [PW-1:0] p,
                          input logic [ST-1:0] t, input logic sb);
        we2 = 1; waddr2 = a; wsrc1_2 = s1; wvalid1_2 = v1; wsrc2_2 = s2; wvalid2_2 = v2;
        wpayload_2 = p; wspectag_2 = t; wspecbit_2 = sb;
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) cyc();
        reset = 0;
        #1;
        expect_eq("rst_busy",   busyvec, 4'b0000);
        expect_eq("rst_free",   free_cnt, 3'd4);
        expect_eq("rst_iv",     issue_valid, 1'b0);
        expect_eq("rst_addr",   issue_addr, 2'd0);
        expect_eq("rst_src1",   ex_src1, 32'h0);
        expect_eq("rst_pay",    payload, '0);
        expect_eq("rst_sb",     specbit, 1'b0);

        // e0 ready, e1 with src1 pending on tag 5
        alloc1(0, 32'h11, 1, 32'h22, 1, P0, 5'b00000, 0);
        alloc2(1, 32'h5, 0, 32'h33, 1, P1, 5'b00010, 1);
        cyc(); idle(); #1;
        expect_eq("a01_busy", busyvec, 4'b0011);
        expect_eq("a01_free", free_cnt, 3'd2);
        expect_eq("a01_iv",   issue_valid, 1'b1);
        expect_eq("a01_addr", issue_addr, 2'd0);
        expect_eq("a01_src1", ex_src1, 32'h11);
        expect_eq("a01_src2", ex_src2, 32'h22);
        expect_eq("a01_pay",  payload, P0);
        issue_ack = 1;
        cyc(); idle(); #1;
        expect_eq("ack0_busy", busyvec, 4'b0010);
        expect_eq("ack0_iv",   issue_valid, 1'b0);
        issue_ack = 1;
        cyc(); idle(); #1;
        expect_eq("ack_noval_busy", busyvec, 4'b0010);

        // age: e2 then e0, both ready
        alloc1(2, 32'h201, 1, 32'h202, 1, P2, 5'b00000, 0);
        cyc(); idle();
        alloc2(0, 32'h301, 1, 32'h302, 1, P3, 5'b00000, 0);
        #1;
        expect_eq("age_first_addr", issue_addr, 2'd2);
        cyc(); idle(); #1;
        expect_eq("age_busy", busyvec, 4'b0111);
        expect_eq("age_addr", issue_addr, 2'd2);
        expect_eq("age_src1", ex_src1, 32'h201);
        expect_eq("age_pay",  payload, P2);
        cyc(); #1;
        expect_eq("age_hold", issue_addr, 2'd2);
        issue_ack = 1;
        cyc(); idle(); #1;
        expect_eq("age_next_addr", issue_addr, 2'd0);
        expect_eq("age_next_src1", ex_src1, 32'h301);
        expect_eq("age_next_busy", busyvec, 4'b0011);
        issue_ack = 1;
        cyc(); idle(); #1;
        expect_eq("age_done_busy", busyvec, 4'b0010);
        expect_eq("age_done_iv",   issue_valid, 1'b0);

        // wakeup squashed by kill_spec
        exdst[3*RS +: RS] = 6'd5; exrslt[3*DL +: DL] = 32'hBEEF;
        #1;
        expect_eq("kill_byp", dut.g_ent[1].u_ent.ex_src1_o, 32'h5);
        cyc(); idle(); #1;
        expect_eq("kill_iv", issue_valid, 1'b0);

        // wakeup with two matching ports: port 3 beats port 5
        kill_spec = '0;
        exdst[3*RS +: RS] = 6'd5; exrslt[3*DL +: DL] = 32'hDEAD;
        exdst[5*RS +: RS] = 6'd5; exrslt[5*DL +: DL] = 32'h5555;
        #1;
        expect_eq("wake_byp", dut.g_ent[1].u_ent.ex_src1_o, 32'hDEAD);
        expect_eq("wake_no_promo", issue_valid, 1'b0);
        cyc(); idle(); #1;
        expect_eq("wake_iv",   issue_valid, 1'b1);
        expect_eq("wake_addr", issue_addr, 2'd1);
        expect_eq("wake_src1", ex_src1, 32'hDEAD);
        expect_eq("wake_src2", ex_src2, 32'h33);
        expect_eq("wake_tag",  spectag, 5'b00010);
        expect_eq("wake_sb",   specbit, 1'b1);

        // e3 younger than e1
        alloc1(3, 32'h401, 1, 32'h402, 1, P4, 5'b00100, 1);
        cyc(); idle(); #1;
        expect_eq("e3_busy", busyvec, 4'b1010);
        expect_eq("e3_addr", issue_addr, 2'd1);

        // mispredict kills e1, drops alloc, clears specbits
        prmiss = 1; specfixtag = 5'b00010;
        alloc1(0, 32'h901, 1, 32'h902, 1, P5, 5'b00000, 0);
        cyc(); idle(); #1;
        expect_eq("miss_busy", busyvec, 4'b1000);
        expect_eq("miss_free", free_cnt, 3'd3);
        expect_eq("miss_addr", issue_addr, 2'd3);
        expect_eq("miss_sb",   specbit, 1'b0);
        expect_eq("miss_tag",  spectag, 5'b00100);

        // prsuccess with same-cycle alloc on the resolving tag
        prsuccess = 1; prtag = 5'b00100;
        alloc1(0, 32'h501, 1, 32'h502, 1, P6, 5'b00100, 1);
        cyc(); idle(); #1;
        expect_eq("succ_busy", busyvec, 4'b1001);
        expect_eq("succ_addr", issue_addr, 2'd3);
        issue_ack = 1;
        cyc(); idle(); #1;
        expect_eq("succ_e0_addr", issue_addr, 2'd0);
        expect_eq("succ_e0_sb",   specbit, 1'b0);
        expect_eq("succ_e0_tag",  spectag, 5'b00100);
        expect_eq("succ_e0_src1", ex_src1, 32'h501);
        expect_eq("succ_e0_pay",  payload, P6);

        // specbit output reflects a same-cycle prsuccess
        issue_ack = 1;
        alloc1(2, 32'h601, 1, 32'h602, 1, P7, 5'b01000, 1);
        cyc(); idle(); #1;
        expect_eq("sb_busy", busyvec, 4'b0100);
        expect_eq("sb_addr", issue_addr, 2'd2);
        expect_eq("sb_set",  specbit, 1'b1);
        prsuccess = 1; prtag = 5'b01000;
        #1;
        expect_eq("sb_comb_clr", specbit, 1'b0);
        cyc(); idle(); #1;
        expect_eq("sb_reg_clr", specbit, 1'b0);

        // alloc into a busy entry is ignored
        alloc1(2, 32'hAAA, 1, 32'hBBB, 1, P8, 5'b00000, 0);
        cyc(); idle(); #1;
        expect_eq("busy_alloc_pay",  payload, P7);
        expect_eq("busy_alloc_busy", busyvec, 4'b0100);

        // both slots to the same entry: ignored
        alloc1(0, 32'h1, 1, 32'h2, 1, P8, 5'b00000, 0);
        alloc2(0, 32'h3, 1, 32'h4, 1, P8, 5'b00000, 0);
        cyc(); idle(); #1;
        expect_eq("same_addr_busy", busyvec, 4'b0100);

        // reset mid-operation with three busy entries
        alloc1(0, 32'h71, 1, 32'h72, 1, P0, 5'b00000, 0);
        alloc2(1, 32'h73, 1, 32'h74, 1, P1, 5'b00000, 0);
        cyc(); idle(); #1;
        expect_eq("pre_rst_busy", busyvec, 4'b0111);
        expect_eq("pre_rst_free", free_cnt, 3'd1);
        reset = 1;
        cyc();
        reset = 0;
        #1;
        expect_eq("mid_rst_busy", busyvec, 4'b0000);
        expect_eq("mid_rst_iv",   issue_valid, 1'b0);
        expect_eq("mid_rst_free", free_cnt, 3'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_fpga_param.md
Name: rs_fpga_param

Overview:
Parametrised successor to the 2-entry FPGA-unit reservation station. Holds ENT_NUM dispatched FPGA ops with two source operands and an opaque payload (imm, rrftag, dstval, src_a/src_b, funct7/funct3, passbits). Snoops NUM_WB result buses for operand wakeup and tracks speculation per entry. New over the old block: internal oldest-ready select with a valid/ack issue handshake, and allocation that is kept on prsuccess.

Parameters:
ENT_NUM, 4, entries (power of 2, >=2)
ENT_SEL, 2, log2(ENT_NUM)
NUM_WB, 7, result-bus snoop ports
DATA_LEN, 32, operand width
RRF_SEL, 6, rename tag width
SPECTAG_LEN, 5, one-hot branch tag width
PAY_W, 108, packed payload width (imm+rrftag+dstval+src_a+src_b+funct7+funct3+passbits)

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
we1, we2  in  1  alloc strobes; we1 is older
waddr1, waddr2  in  ENT_SEL  target entries
wsrc1_k, wsrc2_k  in  DATA_LEN  operand value, or RRF tag in low bits if not valid (k=1,2)
wvalid1_k, wvalid2_k  in  1  operand ready
wpayload_k  in  PAY_W  packed payload
wspectag_k  in  SPECTAG_LEN  branch tag
wspecbit_k  in  1  speculative flag
busyvec  out  ENT_NUM  occupied entries
free_cnt  out  ENT_SEL+1  number of non-busy entries
prmiss, prsuccess  in  1  branch resolve
prtag, specfixtag  in  SPECTAG_LEN  resolving tag / kill mask
exrslt  in  NUM_WB*DATA_LEN  result buses, port p at [p*DATA_LEN +: DATA_LEN]
exdst  in  NUM_WB*RRF_SEL  result dest tags
kill_spec  in  NUM_WB  result squashed
issue_valid  out  1  a ready entry is selected
issue_ack  in  1  consumer takes the selected entry
issue_addr  out  ENT_SEL  selected entry
ex_src1, ex_src2  out  DATA_LEN  selected operands
payload  out  PAY_W  selected payload
spectag  out  SPECTAG_LEN  selected entry's tag
specbit  out  1  selected entry's spec flag, post-prsuccess

Behaviour:
- Reset: busyvec=0; specbits=0; age matrix=0; all entry fields=0. Hence issue_valid=0, free_cnt=ENT_NUM, data outputs 0.
- Alloc: writes land at the next edge. Alloc to a busy entry, or we1 and we2 to the same waddr, is ignored entirely.
- Alloc is dropped on prmiss and kept on prsuccess.
- Wakeup, per operand: if !valid and port p has exdst==src[RRF_SEL-1:0] and !kill_spec[p], load exrslt[p] and set valid next cycle. Multiple matches: lowest p wins. Wakeup also applies in the alloc cycle against the incoming wsrc.
- Bypass: ex_src forwards same-cycle wakeup data. ready[i] = busy & registered valid1 & valid2, so there is no same-cycle ready promotion.
- Age: older[i][j] means entry i is older than entry j. On alloc of entry k, set older[i][k]=1 for every busy i and clear row k. For a dual alloc, also set older[waddr1][waddr2]=1.
- Select: entry i wins if ready[i] and no ready j has older[j][i]. issue_valid=|ready. All issue outputs are combinational from the winner. With issue_valid=0, issue_addr=0 and data outputs show entry 0.
- Issue: issue_ack while issue_valid clears that entry's busy next cycle. Ack without issue_valid is ignored.
- prmiss: clear busy where (spectag & specfixtag)!=0; clear all specbits; the ack clear still applies.
- prsuccess: clear specbit where spectag==prtag, including same-cycle allocs. specbit output reflects the post-clear value.
- prmiss and prsuccess together: prmiss has priority.
- free_cnt = popcount(~busyvec), registered view.

Decomposition:
- Shared package holds: ENT/WB defaults, the payload pack/unpack struct, and the `spec_kill(spectag, mask)` helper.
- Sub-module rs_fpga_ent: one entry. It holds operands, the wakeup compare over NUM_WB ports, payload and spectag, and exports ready and bypassed ex_src.
- The top level owns busy/specbit/age state, select, and output muxes.

Test Plan:
- Alloc e0 (both operands valid) and e1 (src1 tag 5 pending) -> free_cnt 4→2; issue_valid=1, issue_addr=0; ack → busyvec=0b0010.
- exdst[3]=5, exrslt[3]=0xDEAD while e1 pending -> ex_src1=0xDEAD that cycle, ready next cycle. Same tag with kill_spec[3]=1 -> stays pending.
- Alloc e2 then e0, both ready, no ack -> issue_addr=2 held until ack, then 0.
- e1 spectag 0b00010, e3 spectag 0b00100, specfixtag 0b00010, prmiss -> e1 freed, e3 kept, all specbits 0. The alloc in that cycle is dropped.
- prsuccess, prtag 0b00100, with same-cycle alloc (wspecbit=1, wspectag 0b00100) -> alloc kept, its specbit=0.
- reset asserted mid-operation with 3 busy -> next cycle busyvec=0, issue_valid=0, free_cnt=4.
